switch_mcu_regfile: RTL and testbench



---
 rtl/switch_mcu_regfile.sv | 103 ++++++++++
 tb/tb_switch_mcu_regfile.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_mcu_regfile.sv
// General-purpose register file for the switch MCU core: 2**ADDR_W x DATA_W,
// two registered read ports with write-first bypass, one write port, x0 tied to zero.
module switch_mcu_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_ren_1,
   input  logic [ADDR_W-1:0] in_raddr_1,
   output logic [DATA_W-1:0] out_rdata_1,
   output logic              out_rvalid_1,
   input  logic              in_ren_2,
   input  logic [ADDR_W-1:0] in_raddr_2,
   output logic [DATA_W-1:0] out_rdata_2,
   output logic              out_rvalid_2,
   input  logic              in_wen,
   input  logic [ADDR_W-1:0] in_waddr,
   input  logic [DATA_W-1:0] in_wdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] w_regs [DEPTH];
   logic [DATA_W-1:0] w_rd_1;
   logic [DATA_W-1:0] w_rd_2;
   logic              w_wr_live;
   logic [DATA_W-1:0] r_rdata_1;
   logic [DATA_W-1:0] r_rdata_2;
   logic              r_rvalid_1;
   logic              r_rvalid_2;

   // x0 has no storage; it always reads as zero
   assign w_regs[0]  = {DATA_W{1'b0}};
   assign w_wr_live  = in_wen && (in_waddr != {ADDR_W{1'b0}});

   for (genvar g = 1; g < DEPTH; g++) begin : g_reg
      logic [DATA_W-1:0] r_reg;

      // Storage for register g; only a write addressed to g updates it
      always_ff @(posedge in_clk or negedge in_rst) begin
         if (!in_rst) begin
            r_reg <= {DATA_W{1'b0}};
         end else if (in_wen && (in_waddr == ADDR_W'(g))) begin
            r_reg <= in_wdata;
         end
      end

      assign w_regs[g] = r_reg;
   end

   // Port 1 read source: same-edge write to the same live address wins
   always_comb begin
      w_rd_1 = w_regs[in_raddr_1];
      if (w_wr_live && (in_raddr_1 == in_waddr)) begin
         w_rd_1 = in_wdata;
      end else begin
         w_rd_1 = w_regs[in_raddr_1];
      end
   end

   // Port 2 read source: same-edge write to the same live address wins
   always_comb begin
      w_rd_2 = w_regs[in_raddr_2];
      if (w_wr_live && (in_raddr_2 == in_waddr)) begin
         w_rd_2 = in_wdata;
      end else begin
         w_rd_2 = w_regs[in_raddr_2];
      end
   end

   // Port 1 output register: data held between reads, valid pulses per read
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_rdata_1  <= {DATA_W{1'b0}};
         r_rvalid_1 <= 1'b0;
      end else if (in_ren_1) begin
         r_rdata_1  <= w_rd_1;
         r_rvalid_1 <= 1'b1;
      end else begin
         r_rvalid_1 <= 1'b0;
      end
   end

   // Port 2 output register: data held between reads, valid pulses per read
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_rdata_2  <= {DATA_W{1'b0}};
         r_rvalid_2 <= 1'b0;
      end else if (in_ren_2) begin
         r_rdata_2  <= w_rd_2;
         r_rvalid_2 <= 1'b1;
      end else begin
         r_rvalid_2 <= 1'b0;
      end
   end

   assign out_rdata_1  = r_rdata_1;
   assign out_rvalid_1 = r_rvalid_1;
   assign out_rdata_2  = r_rdata_2;
   assign out_rvalid_2 = r_rvalid_2;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Self-checking bench for switch_mcu_regfile: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_switch_mcu_regfile;

   logic        in_clk = 1'b0;
   logic        in_rst = 1'b0;
   logic        in_ren_1 = 1'b0;
   logic [4:0]  in_raddr_1 = 5'd0;
   logic [31:0] out_rdata_1;
   logic        out_rvalid_1;
   logic        in_ren_2 = 1'b0;
   logic [4:0]  in_raddr_2 = 5'd0;
   logic [31:0] out_rdata_2;
   logic        out_rvalid_2;
   logic        in_wen = 1'b0;
   logic [4:0]  in_waddr = 5'd0;
   logic [31:0] in_wdata = 32'd0;

   int n_checks = 0;
   int n_errors = 0;

   // Model: architectural register contents and expected post-edge outputs
   logic [31:0] m_mem [32];
   logic [31:0] exp_rd1 = 32'd0;
   logic [31:0] exp_rd2 = 32'd0;
   logic        exp_v1 = 1'b0;
   logic        exp_v2 = 1'b0;

   switch_mcu_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .in_clk      (in_clk),
      .in_rst      (in_rst),
      .in_ren_1    (in_ren_1),
      .in_raddr_1  (in_raddr_1),
      .out_rdata_1 (out_rdata_1),
      .out_rvalid_1(out_rvalid_1),
      .in_ren_2    (in_ren_2),
      .in_raddr_2  (in_raddr_2),
      .out_rdata_2 (out_rdata_2),
      .out_rvalid_2(out_rvalid_2),
      .in_wen      (in_wen),
      .in_waddr    (in_waddr),
      .in_wdata    (in_wdata)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      exp_rd1 = 32'd0;
      exp_rd2 = 32'd0;
      exp_v1  = 1'b0;
      exp_v2  = 1'b0;
   endtask

   // Apply inputs for the coming edge and advance the model: write lands first,
   // then reads see the updated contents (write-first); x0 is never stored.
   task automatic drive(input bit r1, input logic [4:0] a1, input bit r2, input logic [4:0] a2,
                        input bit w, input logic [4:0] wa, input logic [31:0] wd);
      @(negedge in_clk);
      in_ren_1 = r1; in_raddr_1 = a1;
      in_ren_2 = r2; in_raddr_2 = a2;
      in_wen = w; in_waddr = wa; in_wdata = wd;
      if (in_rst) begin
         if (w && wa != 5'd0) m_mem[wa] = wd;
         exp_v1 = r1;
         exp_v2 = r2;
         if (r1) exp_rd1 = m_mem[a1];
         if (r2) exp_rd2 = m_mem[a2];
      end
   endtask

   task automatic idle();
      drive(1'b0, 5'($urandom), 1'b0, 5'($urandom), 1'b0, 5'($urandom), $urandom);
   endtask

   task automatic settle();
      @(posedge in_clk);
      #2;
   endtask

   // Per-cycle compare of DUT outputs against the model, just after each edge
   always @(posedge in_clk) begin
      #1;
      check("cyc_rdata_1", out_rdata_1, exp_rd1);
      check("cyc_rdata_2", out_rdata_2, exp_rd2);
      check("cyc_rvalid_1", {31'd0, out_rvalid_1}, {31'd0, exp_v1});
      check("cyc_rvalid_2", {31'd0, out_rvalid_2}, {31'd0, exp_v2});
   end

   initial begin
      logic [31:0] slti_rs1;
      logic [31:0] slti_res;
      model_clear();
      #3;
      check("rst_rdata_1", out_rdata_1, 32'h0000_0000);
      check("rst_rvalid_1", {31'd0, out_rvalid_1}, 32'd0);
      check("rst_rdata_2", out_rdata_2, 32'h0000_0000);
      check("rst_rvalid_2", {31'd0, out_rvalid_2}, 32'd0);
      @(negedge in_clk);
      in_rst = 1'b1;

      // Write then read, then hold with enable low
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h1234_5678);
      drive(1'b1, 5'd3, 1'b0, 5'd9, 1'b0, 5'd0, 32'd0);
      settle();
      check("wr_rd_data", out_rdata_1, 32'h1234_5678);
      check("wr_rd_valid", {31'd0, out_rvalid_1}, 32'd1);
      check("model_pin_wr_rd", exp_rd1, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         idle();
         settle();
         check("hold_data", out_rdata_1, 32'h1234_5678);
         check("hold_valid", {31'd0, out_rvalid_1}, 32'd0);
      end

      // x0 behaviour
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
      settle();
      check("x0_rd_1", out_rdata_1, 32'h0000_0000);
      check("x0_rd_2", out_rdata_2, 32'h0000_0000);
      drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hCAFE_F00D);
      settle();
      check("x0_bypass", out_rdata_1, 32'h0000_0000);

      // Write-first bypass on port 2
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_0001);
      drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5);
      settle();
      check("bypass_rd_2", out_rdata_2, 32'hA5A5_A5A5);
      check("model_pin_bypass", exp_rd2, 32'hA5A5_A5A5);
      drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
      settle();
      check("after_bypass_1", out_rdata_1, 32'hA5A5_A5A5);
      check("after_bypass_2", out_rdata_2, 32'hA5A5_A5A5);

      // Dual-port independence
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'h0000_0011);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h0000_0022);
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0);
      settle();
      check("dual_1", out_rdata_1, 32'h0000_0011);
      check("dual_2", out_rdata_2, 32'h0000_0022);
      drive(1'b1, 5'd2, 1'b0, 5'd1, 1'b0, 5'd0, 32'd0);
      settle();
      check("dual_p1_only", out_rdata_1, 32'h0000_0022);
      check("dual_p2_held", out_rdata_2, 32'h0000_0022);
      check("dual_p2_valid", {31'd0, out_rvalid_2}, 32'd0);

      // ALU SLTI handshake: rs1=x4, rd=x9, imm=1
      slti_rs1 = 32'hFFFF_FFF0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, slti_rs1);
      drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      for (int c = 2; c <= 4; c++) begin
         settle();
         check("alu_rs1_stable", out_rdata_1, 32'hFFFF_FFF0);
         if (c < 4) idle();
      end
      slti_res = ($signed(out_rdata_1) < $signed(32'h0000_0001)) ? 32'd1 : 32'd0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, slti_res);
      drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      settle();
      check("alu_rd_result", out_rdata_1, 32'h0000_0001);

      // Asynchronous reset mid-operation with a read and write in flight
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
      settle();
      check("pre_rst_rd", out_rdata_1, 32'hDEAD_BEEF);
      drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd6, 32'h5555_AAAA);
      #2;
      in_rst = 1'b0;
      model_clear();
      #1;
      check("mid_rst_rdata_1", out_rdata_1, 32'h0000_0000);
      check("mid_rst_rdata_2", out_rdata_2, 32'h0000_0000);
      check("mid_rst_rvalid_1", {31'd0, out_rvalid_1}, 32'd0);
      check("mid_rst_rvalid_2", {31'd0, out_rvalid_2}, 32'd0);
      idle();
      in_rst = 1'b1;
      drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0);
      settle();
      check("post_rst_rd5", out_rdata_1, 32'h0000_0000);
      check("post_rst_rd6", out_rdata_2, 32'h0000_0000);
      check("post_rst_valid", {31'd0, out_rvalid_1}, 32'd1);

      // Randomized traffic; narrow address range half the time to force collisions
      for (int i = 0; i < 600; i++) begin
         logic [4:0] a1, a2, wa;
         bit narrow;
         narrow = ($urandom_range(0, 1) == 1);
         a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         drive(1'($urandom), a1, 1'($urandom), a2, 1'($urandom), wa, $urandom);
      end
      idle();
      settle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
